shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Sequencer for a WIDTH-bit full-duplex serial shift path.
- Accepts a parallel word over a valid/ready handshake, then shifts it out on sout one bit per shift tick.
- Captures sin into a receive word on the same ticks, then presents that word over an output valid/ready handshake.
- Sits between parallel producer/consumer logic and the serial-in/serial-out and serial-in/parallel-out shift registers; it owns their timing and shift pacing.

Parameters:
- WIDTH, 4: bits per transfer; legal values ≥ 2.
- CLK_DIV, 1: clk cycles per shift tick; legal values ≥ 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  parallel word to transmit.
- sin  input  1  serial receive bit.
- sout  output  1  serial transmit bit.
- shift_tick  output  1  one-cycle pulse on each shift tick; drives the enable of the external shift registers.
- busy  output  1  high in SHIFT and DONE.
- out_valid  output  1  out_data holds a completed received word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  received word.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-low.
- Reset (rst=0 at a clk edge):
  - state IDLE; tx_sreg, rx_sreg, bit_cnt and div_cnt cleared.
  - Outputs after that edge: in_ready=1, sout=0, shift_tick=0, busy=0, out_valid=0, out_data=0.
  - Reset mid-transfer aborts immediately; any partial word is discarded.
- States: IDLE → SHIFT → DONE → IDLE.
- IDLE:
  - in_ready=1, sout=0.
  - On an edge with in_valid=1: tx_sreg←in_data, rx_sreg←0, bit_cnt←0, div_cnt←0, go to SHIFT.
- SHIFT:
  - in_ready=0. sout is driven from a register: tx_sreg[WIDTH-1], MSB first.
  - div_cnt counts 0..CLK_DIV-1 and wraps. A tick is the edge where div_cnt==CLK_DIV-1.
  - shift_tick is high during the cycle that ends in a tick edge (combinational: state==SHIFT && div_cnt==CLK_DIV-1).
  - At each tick edge: tx_sreg shifts left, filling with 0; rx_sreg←{rx_sreg[WIDTH-2:0], sin}; bit_cnt increments.
  - At the tick edge where bit_cnt==WIDTH-1: out_data←{rx_sreg[WIDTH-2:0], sin}, out_valid←1, go to DONE.
- Timing, with the accept edge called E0:
  - Bit i (i=0..WIDTH-1) is on sout from edge E0+i·CLK_DIV until edge E0+(i+1)·CLK_DIV.
  - sin is sampled at edges E0+(i+1)·CLK_DIV.
  - out_valid rises after edge E0+WIDTH·CLK_DIV.
- DONE:
  - sout=0; out_valid and out_data are held stable until an edge with out_ready=1.
  - On that edge: out_valid←0, go to IDLE; in_ready=1 on the following cycle. There is no same-cycle bypass.
- in_valid while in_ready=0 is ignored. out_ready while out_valid=0 is ignored.
- Counter widths: bit_cnt is $clog2(WIDTH+1) bits; div_cnt is max(1,$clog2(CLK_DIV)) bits. Neither counter passes its terminal value.
- CLK_DIV=1: a tick on every SHIFT cycle; shift_tick stays high throughout SHIFT.

Optional Feature:
- Macro: SHIFT_SEQ_LSB_FIRST_EN.
- Defined:
  - Transmit LSB first: sout=tx_sreg[0], and tx_sreg shifts right filling with 0.
  - Receive LSB first: rx_sreg←{sin, rx_sreg[WIDTH-1:1]}; the completed word is {sin, rx_sreg[WIDTH-1:1]}.
  - Timing and handshakes are unchanged.
- Undefined: MSB-first behaviour as described above.

Test Plan:
- Reset then idle, WIDTH=4, CLK_DIV=1: hold rst=0 for 2 edges → in_ready=1, busy=0, out_valid=0, sout=0, out_data=0.
- Loopback, WIDTH=4, CLK_DIV=1: sin tied to sout, in_data=4'b1011 pulsed for 1 cycle, out_ready=1:
  - sout reads 1,0,1,1 on cycles E0+1..E0+4.
  - shift_tick is high for 4 cycles.
  - out_valid pulses for 1 cycle after edge E0+4 with out_data=4'b1011.
  - in_ready=1 again after edge E0+5.
- Divided pacing, CLK_DIV=3, in_data=4'b0110, sin driven 1,1,0,1 per tick:
  - each sout bit is held for 3 cycles; shift_tick pulses every 3rd cycle.
  - out_data=4'b1101 after edge E0+12.
- Output backpressure: out_ready=0 for 5 cycles after completion → out_valid and out_data stay stable, in_ready=0, and in_valid=1 with new data is ignored; out_ready=1 → IDLE on the next edge.
- Reset mid-transfer: rst=0 at tick 2 of 4 → IDLE on the next edge, out_valid never asserts, sout=0; a new transfer of 4'b1001 then completes correctly.
- With SHIFT_SEQ_LSB_FIRST_EN, loopback, in_data=4'b1011: sout reads 1,1,0,1 and out_data=4'b1011.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Parallel/serial handshake bundle for shift_seq_ctrl; slave = sequencer, master = producer/consumer side.
interface shift_seq_ctrl_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sin;
  logic             sout;
  logic             shift_tick;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, sin, out_ready,
    output in_ready, sout, shift_tick, busy, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, sin, out_ready,
    input  in_ready, sout, shift_tick, busy, out_valid, out_data
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Full-duplex shift sequencer: word in, WIDTH bits out/in at one bit per CLK_DIV cycles, word out; held until out_ready.
// SHIFT_SEQ_LSB_FIRST_EN selects LSB-first transmit/receive (default MSB-first).
module shift_seq_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CLK_DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  shift_seq_ctrl_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;

  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_next;
  logic             tx_bit;
  logic             tick;

`ifdef SHIFT_SEQ_LSB_FIRST_EN
  assign tx_bit   = tx_q[0];
  assign tx_shift = {1'b0, tx_q[WIDTH-1:1]};
  assign rx_next  = {bus.sin, rx_q[WIDTH-1:1]};
`else
  assign tx_bit   = tx_q[WIDTH-1];
  assign tx_shift = {tx_q[WIDTH-2:0], 1'b0};
  assign rx_next  = {rx_q[WIDTH-2:0], bus.sin};
`endif

  assign tick           = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);
  assign bus.shift_tick = tick;
  // Gate with state so sout is quiet outside SHIFT regardless of tx_q contents.
  assign bus.sout       = (state_q == SHIFT) & tx_bit;
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          tx_d      = bus.in_data;
          rx_d      = '0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          tx_d      = tx_shift;
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            out_data_d  = rx_next;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: a CLK_DIV=1 instance (loopback, mid-transfer reset) and a CLK_DIV=3 instance (pacing, backpressure).
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic loop1;
  logic sin1_drv;
  int   n_vec = 0;
  int   n_bad = 0;

  shift_seq_ctrl_if #(.WIDTH(4)) b1 ();
  shift_seq_ctrl_if #(.WIDTH(4)) b3 ();

  assign b1.sin = loop1 ? b1.sout : sin1_drv;

  shift_seq_ctrl #(.WIDTH(4), .CLK_DIV(1)) u_d1 (.clk(clk), .rst(rst), .bus(b1));
  shift_seq_ctrl #(.WIDTH(4), .CLK_DIV(3)) u_d3 (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial bit i of a 4-bit word in the configured bit order.
  function automatic logic exp_bit(input logic [3:0] d, input int i);
`ifdef SHIFT_SEQ_LSB_FIRST_EN
    return d[i];
`else
    return d[3-i];
`endif
  endfunction

  initial begin
    logic [3:0] word;
    logic [3:0] sin_seq;
    logic [3:0] exp_rx;

    rst = 1'b0; loop1 = 1'b1; sin1_drv = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0; b3.sin = 1'b0;
    cyc(); cyc();
    chk("rst_in_ready",  32'(b1.in_ready), 32'd1);
    chk("rst_busy",      32'(b1.busy), 32'd0);
    chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
    chk("rst_sout",      32'(b1.sout), 32'd0);
    chk("rst_out_data",  32'(b1.out_data), 32'd0);
    chk("rst_tick",      32'(b1.shift_tick), 32'd0);
    chk("rst_d3_ready",  32'(b3.in_ready), 32'd1);
    rst = 1'b1;
    cyc();
    chk("idle_hold", 32'(b1.in_ready), 32'd1);

    // Loopback, CLK_DIV=1
    word = 4'b1011;
    b1.in_data = word; b1.in_valid = 1'b1;
    cyc();                       // E0
    b1.in_valid = 1'b0; b1.in_data = 4'hF;
    chk("lb_busy",     32'(b1.busy), 32'd1);
    chk("lb_in_ready", 32'(b1.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lb_sout%0d", i), 32'(b1.sout), 32'(exp_bit(word, i)));
      chk($sformatf("lb_tick%0d", i), 32'(b1.shift_tick), 32'd1);
      chk($sformatf("lb_ov%0d", i), 32'(b1.out_valid), 32'd0);
      cyc();
    end
    chk("lb_out_valid", 32'(b1.out_valid), 32'd1);
    chk("lb_out_data",  32'(b1.out_data), 32'(word));
    chk("lb_done_tick", 32'(b1.shift_tick), 32'd0);
    chk("lb_done_sout", 32'(b1.sout), 32'd0);
    chk("lb_done_rdy",  32'(b1.in_ready), 32'd0);
    cyc();                       // E0+5
    chk("lb_ov_drop",   32'(b1.out_valid), 32'd0);
    chk("lb_ready_back", 32'(b1.in_ready), 32'd1);

    // Divided pacing, CLK_DIV=3; sin per tick = 1,1,0,1
    word = 4'b0110;
    sin_seq = 4'b1011;           // sin_seq[i] is the bit presented for tick i
`ifdef SHIFT_SEQ_LSB_FIRST_EN
    exp_rx = 4'b1011;
`else
    exp_rx = 4'b1101;
`endif
    b3.in_data = word; b3.in_valid = 1'b1;
    cyc();                       // E0
    b3.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b3.sin = sin_seq[i];
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("dv_sout%0d_%0d", i, j), 32'(b3.sout), 32'(exp_bit(word, i)));
        chk($sformatf("dv_tick%0d_%0d", i, j), 32'(b3.shift_tick), (j == 2) ? 32'd1 : 32'd0);
        cyc();
      end
    end
    b3.sin = 1'b0;
    chk("dv_out_valid", 32'(b3.out_valid), 32'd1);
    chk("dv_out_data",  32'(b3.out_data), 32'(exp_rx));

    // Backpressure: held output, new input ignored
    b3.in_data = 4'b1111; b3.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_ov%0d", k),   32'(b3.out_valid), 32'd1);
      chk($sformatf("bp_data%0d", k), 32'(b3.out_data), 32'(exp_rx));
      chk($sformatf("bp_rdy%0d", k),  32'(b3.in_ready), 32'd0);
      chk($sformatf("bp_busy%0d", k), 32'(b3.busy), 32'd1);
      chk($sformatf("bp_sout%0d", k), 32'(b3.sout), 32'd0);
      cyc();
    end
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b1;
    cyc();
    b3.out_ready = 1'b0;
    chk("bp_release_ov",  32'(b3.out_valid), 32'd0);
    chk("bp_release_rdy", 32'(b3.in_ready), 32'd1);
    cyc();
    chk("bp_no_accept", 32'(b3.busy), 32'd0);

    // Reset mid-transfer on the CLK_DIV=1 instance
    b1.in_data = 4'b0110; b1.in_valid = 1'b1;
    cyc();                       // E0
    b1.in_valid = 1'b0;
    cyc();                       // tick 1
    rst = 1'b0;
    cyc();                       // would have been tick 2
    rst = 1'b1;
    chk("mr_in_ready", 32'(b1.in_ready), 32'd1);
    chk("mr_busy",     32'(b1.busy), 32'd0);
    chk("mr_sout",     32'(b1.sout), 32'd0);
    chk("mr_ov",       32'(b1.out_valid), 32'd0);
    chk("mr_data",     32'(b1.out_data), 32'd0);
    cyc(); cyc();
    chk("mr_ov_quiet", 32'(b1.out_valid), 32'd0);

    word = 4'b1001;
    b1.in_data = word; b1.in_valid = 1'b1;
    cyc();                       // E0
    b1.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mr2_sout%0d", i), 32'(b1.sout), 32'(exp_bit(word, i)));
      cyc();
    end
    chk("mr2_out_valid", 32'(b1.out_valid), 32'd1);
    chk("mr2_out_data",  32'(b1.out_data), 32'(word));
    cyc();
    chk("mr2_idle", 32'(b1.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
